// File: rtl/spi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_host_ctrl
// Description : SPI mode-0 initiator issuing one 16-bit register read/write
//               frame per request, returning read data with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_host_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int FRAME_W = 2 * WIDTH;
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] DATA_TOP = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_SCLK_HI = 3'd2,
    S_SCLK_LO = 3'd3,
    S_HOLD    = 3'd4,
    S_GAP     = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 last_q, last_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [WIDTH-1:0]     miso_sr_q, miso_sr_d;
  logic                 rw_q, rw_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;

  logic                 w_cnt_done;
  logic                 w_rise;
  logic [WIDTH-2:0]     w_addr_ext;
  logic [FRAME_W-1:0]   w_frame;

  assign w_cnt_done = (cnt_q == CNT_LAST);
  assign w_addr_ext = (WIDTH - 1)'(addr);
  assign w_frame    = {rw, w_addr_ext, (rw ? wdata : {WIDTH{1'b0}})};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    last_d    = last_q;
    frame_d   = frame_q;
    miso_sr_d = miso_sr_q;
    rw_d      = rw_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    w_rise    = 1'b0;

    if ((state_q != S_IDLE) && !ena) begin
      // Abort: drop back to idle with the bus released, no done pulse.
      state_d = S_IDLE;
      cnt_d   = '0;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        cnt_d = w_cnt_done ? '0 : cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (start && ena) begin
            state_d  = S_SETUP;
            cnt_d    = '0;
            frame_d  = w_frame;
            rw_d     = rw;
            bitcnt_d = BIT_TOP;
            last_d   = 1'b0;
            cs_n_d   = 1'b0;
            mosi_d   = w_frame[FRAME_W-1];
            busy_d   = 1'b1;
          end
        end
        S_SETUP: begin
          if (w_cnt_done) begin
            state_d = S_SCLK_HI;
            w_rise  = 1'b1;
          end
        end
        S_SCLK_HI: begin
          if (w_cnt_done) begin
            state_d  = S_SCLK_LO;
            sclk_d   = 1'b0;
            last_d   = (bitcnt_q == '0);
            bitcnt_d = bitcnt_q - BIT_W'(1);
            frame_d  = frame_q << 1;
            mosi_d   = frame_q[FRAME_W-2];
          end
        end
        S_SCLK_LO: begin
          if (w_cnt_done) begin
            if (last_q) begin
              state_d = S_HOLD;
            end else begin
              state_d = S_SCLK_HI;
              w_rise  = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_cnt_done) begin
            state_d = S_GAP;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
          end
        end
        S_GAP: begin
          if (w_cnt_done) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (!rw_q) begin
              rdata_d = miso_sr_q;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // MISO is captured on the edge raising SCLK, data byte only.
      if (w_rise) begin
        sclk_d = 1'b1;
        if (bitcnt_q <= DATA_TOP) begin
          miso_sr_d = {miso_sr_q[WIDTH-2:0], spi_miso};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      last_q    <= 1'b0;
      frame_q   <= '0;
      miso_sr_q <= '0;
      rw_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      last_q    <= last_d;
      frame_q   <= frame_d;
      miso_sr_q <= miso_sr_d;
      rw_q      <= rw_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_host_ctrl
// Description : Scoreboard bench for spi_host_ctrl with a MISO slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_host_ctrl;

  localparam int CD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       spi_miso = 1'b0;
  logic       busy, done, spi_cs_n, spi_clk, spi_mosi;
  logic [7:0] rdata;

  logic       start1 = 1'b0;
  logic       busy1, done1, cs1, sclk1, mosi1;
  logic [7:0] rdata1;
  logic       miso1 = 1'b0;

  spi_host_ctrl #(.WIDTH(8), .ADDR_WIDTH(3), .CLK_DIV(CD)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_host_ctrl #(.WIDTH(8), .ADDR_WIDTH(3), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy1), .done(done1), .rdata(rdata1), .spi_cs_n(cs1),
    .spi_clk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_exp = 0;
  int          done_cnt = 0;
  logic [7:0]  model_rdata = '0;
  logic [15:0] slave_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor + slave model, sampled on the falling clk edge
  logic        prev_busy = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1;
  int          t0 = 0, nrise = 16, cs_rise_off = -1, cs_high_len = 0, frames_seen = 0;
  bit          timing_bad = 1'b0;
  logic [15:0] cap = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      nrise     = 16;
      spi_miso  = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        t0 = cyc; nrise = 0; cap = '0; timing_bad = 1'b0; cs_rise_off = -1;
      end
      if (spi_clk && !prev_sclk) begin
        if ((cyc - t0) != CD * (1 + 2 * nrise)) timing_bad = 1'b1;
        cap = {cap[14:0], spi_mosi};
        nrise++;
      end
      if (spi_cs_n && !prev_cs) cs_rise_off = cyc - t0;
      if (!spi_cs_n && prev_cs) begin
        if (frames_seen > 0) check("cs_gap_ge_div", 32'(cs_high_len >= CD), 32'd1);
        frames_seen++;
      end
      cs_high_len = spi_cs_n ? cs_high_len + 1 : 0;
      if (done) begin
        done_cnt++;
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("mosi_frame", 32'(cap), 32'(e.frame));
          check("rise_count", 32'(nrise), 32'd16);
          check("sclk_timing_bad", 32'(timing_bad), 32'd0);
          check("cs_rise_offset", 32'(cs_rise_off), 32'(34 * CD));
          check("done_latency", 32'(cyc - t0), 32'(35 * CD));
          check("rdata", 32'(rdata), 32'(e.rdata));
          check("busy_in_done", 32'(busy), 32'd0);
        end
      end
      spi_miso  = (nrise < 16) ? slave_word[15 - nrise] : 1'b0;
      prev_busy = busy;
      prev_sclk = spi_clk;
      prev_cs   = spi_cs_n;
    end
  end

  task automatic push_exp(input logic r, input logic [2:0] a, input logic [7:0] d, input logic [15:0] w);
    exp_t e;
    e.frame = {r, 4'b0000, a, (r ? d : 8'h00)};
    e.rdata = r ? model_rdata : w[7:0];
    model_rdata = e.rdata;
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic send(input logic r, input logic [2:0] a, input logic [7:0] d,
                      input logic [15:0] w, input bit expect_done);
    @(negedge clk); #1;
    rw = r; addr = a; wdata = d; slave_word = w; start = 1'b1;
    if (expect_done) push_exp(r, a, d, w);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (nrise < target && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (nrise < target) check("rise_timeout", 32'(nrise), 32'(target));
  endtask

  task automatic run_cd1();
    logic [15:0] cap1;
    int   rises, dones, done_at;
    logic ps;
    bit   tbad;
    cap1 = '0; rises = 0; dones = 0; done_at = -1; ps = 1'b0; tbad = 1'b0;
    @(negedge clk); #1;
    rw = 1'b1; addr = 3'h2; wdata = 8'hA5; start1 = 1'b1;
    @(negedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      start1 = 1'b0;
      if (sclk1 && !ps) begin
        if (i != 1 + 2 * rises) tbad = 1'b1;
        cap1 = {cap1[14:0], mosi1};
        rises++;
        if (rises == 7) begin
          rw = 1'b0; addr = 3'h7; wdata = 8'h00; start1 = 1'b1;
        end
      end
      ps = sclk1;
      if (done1) begin
        dones++;
        done_at = i;
      end
      @(negedge clk); #1;
    end
    check("cd1_mosi_frame", 32'(cap1), 32'h82A5);
    check("cd1_rise_count", 32'(rises), 32'd16);
    check("cd1_sclk_timing_bad", 32'(tbad), 32'd0);
    check("cd1_done_count", 32'(dones), 32'd1);
    check("cd1_done_latency", 32'(done_at), 32'd35);
    check("cd1_rdata", 32'(rdata1), 32'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write and read
    send(1'b1, 3'h2, 8'hA5, 16'h0000, 1'b1);
    wait_done(n_exp);
    send(1'b0, 3'h4, 8'h77, 16'hFF3C, 1'b1);
    wait_done(n_exp);

    // Back-to-back with start held through the done cycle
    @(negedge clk); #1;
    rw = 1'b0; addr = 3'h1; wdata = 8'h00; slave_word = 16'hFF96; start = 1'b1;
    push_exp(1'b0, 3'h1, 8'h00, 16'hFF96);
    wait_done(n_exp);
    rw = 1'b1; addr = 3'h6; wdata = 8'h5C; slave_word = 16'h1234;
    push_exp(1'b1, 3'h6, 8'h5C, 16'h1234);
    @(negedge clk); #1;
    start = 1'b0;
    check("b2b_busy_second", 32'(busy), 32'd1);
    wait_done(n_exp);

    // Start while busy at bit 9 is ignored
    send(1'b0, 3'h3, 8'h00, 16'h12C7, 1'b1);
    wait_rises(7);
    rw = 1'b1; addr = 3'h7; wdata = 8'hFF; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(n_exp);
    repeat (4) @(negedge clk);

    // Randomized traffic against the reference model
    for (int i = 0; i < 8; i++) begin
      logic       r;
      logic [2:0] a;
      logic [7:0] d;
      logic [15:0] w;
      rnd = $urandom; r = rnd[0]; a = rnd[3:1]; d = rnd[11:4];
      rnd = $urandom; w = rnd[15:0];
      send(r, a, d, w, 1'b1);
      wait_done(n_exp);
    end

    // Abort by dropping ena at bit 5
    send(1'b0, 3'h5, 8'h00, 16'h00E1, 1'b0);
    wait_rises(11);
    ena = 1'b0;
    @(negedge clk); #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sclk", 32'(spi_clk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mosi", 32'(spi_mosi), 32'd0);
    check("abort_rdata", 32'(rdata), 32'(model_rdata));
    repeat (3) @(negedge clk);
    ena = 1'b1;
    send(1'b0, 3'h0, 8'h00, 16'h00A7, 1'b1);
    wait_done(n_exp);

    // Asynchronous reset at bit 12
    send(1'b1, 3'h2, 8'h3D, 16'h0000, 1'b0);
    wait_rises(4);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cs_n", 32'(spi_cs_n), 32'd1);
    check("arst_sclk", 32'(spi_clk), 32'd0);
    check("arst_mosi", 32'(spi_mosi), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdata", 32'(rdata), 32'd0);
    model_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(1'b0, 3'h2, 8'h00, 16'hC35A, 1'b1);
    wait_done(n_exp);

    // CLK_DIV=1 instance: timing plus start while busy
    run_cd1();

    repeat (10) @(negedge clk);
    check("total_done_count", 32'(done_cnt), 32'(n_exp));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
